// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty-ramp controller.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_RAMP    = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RAMP    = 2'b01,
    ST_BR_UP   = 2'b10,
    ST_BR_DOWN = 2'b11
  } ramp_state_t;

  // Bit layout matches the raw switch bundle {mode_in, target_in}.
  typedef struct packed {
    mode_t             mode;
    logic [DUTY_W-1:0] target;
  } ctrl_t;

endpackage

// File: rtl/in_debounce.sv
// Two-flop synchroniser plus stability counter; a value is accepted once it
// has been seen unchanged for DEB_CYCLES consecutive cycles.
module in_debounce #(
  parameter int WIDTH      = 10,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             acc_pulse_o
);

  localparam int            CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Counting never stops; only the hand-over to the accepted register
  // waits for the enable, so a value that settled while disabled is taken
  // on the first enabled cycle.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pulse_d = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (en_i && (cnt_d == CNT_MAX)) begin
      acc_d   = cand_q;
      pulse_d = (cand_q != acc_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
    end
  end

  assign acc_o       = acc_q;
  assign acc_pulse_o = pulse_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Debounced switch front-end that slews an 8-bit PWM duty value:
// direct pass-through, linear ramp, triangle breathe, or hold.
module pwm_duty_ramp
  import pwm_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int RAMP_DIV   = 1024,
  parameter int STEP       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DUTY_W-1:0] target_in,
  input  logic [1:0]        mode_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_upd,
  output logic              at_target
);

  localparam int              PW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(RAMP_DIV - 1);
  localparam logic [DUTY_W:0] STEP9   = (DUTY_W + 1)'(STEP);

  logic [$bits(ctrl_t)-1:0] acc_raw;
  ctrl_t                    acc;
  logic                     acc_pulse;

  ramp_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              upd_q;
  logic [PW-1:0]     presc_q, presc_d;
  mode_t             mode_prev_q;
  logic              mode_chg;
  logic              tick;

  in_debounce #(
    .WIDTH      ($bits(ctrl_t)),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_in_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (ena),
    .raw_i       ({mode_in, target_in}),
    .acc_o       (acc_raw),
    .acc_pulse_o (acc_pulse)
  );

  assign acc = ctrl_t'(acc_raw);

  // Step math is carried in DUTY_W+1 bits so neither direction can wrap.
  function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] d,
                                                input logic [DUTY_W-1:0] lim);
    logic [DUTY_W:0] s;
    s = {1'b0, d} + STEP9;
    return (s > {1'b0, lim}) ? lim : s[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] d,
                                                  input logic [DUTY_W-1:0] lim);
    logic [DUTY_W:0] s;
    s = ({1'b0, d} > STEP9) ? ({1'b0, d} - STEP9) : '0;
    return (s[DUTY_W-1:0] < lim) ? lim : s[DUTY_W-1:0];
  endfunction

  // A mode switch restarts the tick phase so the first step is a full period away.
  assign mode_chg = acc_pulse && (acc.mode != mode_prev_q);
  assign tick     = ena && !mode_chg && (presc_q == PRE_MAX);

  always_comb begin
    if (!ena || mode_chg) begin
      presc_d = '0;
    end else if (presc_q == PRE_MAX) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (ena) begin
      case (acc.mode)
        MODE_DIRECT: begin
          duty_d  = acc.target;
          state_d = ST_IDLE;
        end
        MODE_RAMP: begin
          if (tick) begin
            if (duty_q < acc.target) begin
              duty_d = step_up(duty_q, acc.target);
            end else if (duty_q > acc.target) begin
              duty_d = step_down(duty_q, acc.target);
            end
          end
          state_d = (duty_d != acc.target) ? ST_RAMP : ST_IDLE;
        end
        MODE_BREATHE: begin
          if (acc.target == '0) begin
            duty_d  = '0;
            state_d = ST_IDLE;
          end else begin
            case (state_q)
              ST_BR_UP: begin
                if (tick) begin
                  duty_d = step_up(duty_q, acc.target);
                  if (duty_d == acc.target) state_d = ST_BR_DOWN;
                end
              end
              ST_BR_DOWN: begin
                if (tick) begin
                  duty_d = step_down(duty_q, '0);
                  if (duty_d == '0) state_d = ST_BR_UP;
                end
              end
              default: state_d = ST_BR_UP;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q      <= '0;
      upd_q       <= 1'b0;
      presc_q     <= '0;
      mode_prev_q <= MODE_DIRECT;
    end else begin
      duty_q      <= duty_d;
      upd_q       <= (duty_d != duty_q);
      presc_q     <= presc_d;
      mode_prev_q <= acc.mode;
    end
  end

  always_comb begin
    duty_out  = duty_q;
    duty_upd  = upd_q;
    at_target = (duty_q == acc.target);
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: vector table, directed multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_pwm_duty_ramp;

  localparam int DEB = 4;
  localparam int RD  = 4;
  localparam int ST  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] target_in = 8'h00;
  logic [1:0] mode_in = 2'b00;
  logic [7:0] duty_out;
  logic       duty_upd;
  logic       at_target;

  pwm_duty_ramp #(
    .DEB_CYCLES (DEB),
    .RAMP_DIV   (RD),
    .STEP       (ST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .target_in (target_in),
    .mode_in   (mode_in),
    .duty_out  (duty_out),
    .duty_upd  (duty_upd),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int chg_val[$];
  int chg_cyc[$];
  int upd_cnt;
  int wcyc;

  typedef struct {
    int mode;
    int tgt;
    int exp_duty;
    int exp_at;
    int exp_upd;
  } vec_t;
  vec_t vt[6];

  // Behavioural model state: raw input history and slewed duty.
  int hist[$];
  int m_mode, m_tgt, m_prev, m_pc, m_duty, m_upd;
  bit m_brth, m_up;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int m, input int t);
    mode_in   = m[1:0];
    target_in = t[7:0];
  endtask

  task automatic watch(input int n, input bit clr);
    int last;
    if (clr) begin
      chg_val.delete();
      chg_cyc.delete();
      upd_cnt = 0;
      wcyc    = 0;
    end
    last = int'(duty_out);
    for (int i = 0; i < n; i++) begin
      cyc1();
      wcyc++;
      if (duty_upd) upd_cnt++;
      if (int'(duty_out) != last) begin
        chg_val.push_back(int'(duty_out));
        chg_cyc.push_back(wcyc);
        last = int'(duty_out);
      end
    end
  endtask

  function automatic int qv(input int idx);
    return (idx < chg_val.size()) ? chg_val[idx] : -1;
  endfunction

  function automatic int sv(input int k);
    return (k >= 1) ? hist[k-1] : 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_tgt = 0; m_prev = 0; m_pc = 0;
    m_duty = 0; m_upd = 0; m_brth = 1'b0; m_up = 1'b1;
  endtask

  // One clock edge of the model; raw/en are the values sampled at that edge.
  task automatic model_edge(input int raw, input bit en);
    int n, nd, np;
    bit chg, tk, stable;
    hist.push_back(raw);
    n   = hist.size();
    chg = (m_mode != m_prev);
    tk  = en && !chg && (m_pc == RD - 1);
    np  = (!en || chg) ? 0 : (m_pc + 1) % RD;
    nd  = m_duty;
    if (en) begin
      case (m_mode)
        0: begin
          nd = m_tgt;
          m_brth = 1'b0;
        end
        1: begin
          m_brth = 1'b0;
          if (tk) begin
            if (nd < m_tgt) nd = (nd + ST > m_tgt) ? m_tgt : nd + ST;
            else if (nd > m_tgt) nd = (nd - ST < m_tgt) ? m_tgt : nd - ST;
          end
        end
        2: begin
          if (m_tgt == 0) begin
            nd = 0;
            m_brth = 1'b0;
          end else if (!m_brth) begin
            m_brth = 1'b1;
            m_up   = 1'b1;
          end else if (tk) begin
            if (m_up) begin
              nd = (nd + ST >= m_tgt) ? m_tgt : nd + ST;
              if (nd == m_tgt) m_up = 1'b0;
            end else begin
              nd = (nd <= ST) ? 0 : nd - ST;
              if (nd == 0) m_up = 1'b1;
            end
          end
        end
        default: m_brth = 1'b0;
      endcase
    end
    m_upd  = (nd != m_duty) ? 1 : 0;
    // Accepted once DEB+1 consecutive synchronised samples agree.
    stable = en && (n >= DEB);
    for (int k = n - 2 - DEB; k <= n - 2; k++) begin
      if (sv(k) != sv(n - 2)) stable = 1'b0;
    end
    m_prev = m_mode;
    if (stable) begin
      m_mode = sv(n - 2) >> 8;
      m_tgt  = sv(n - 2) & 255;
    end
    m_pc   = np;
    m_duty = nd;
  endtask

  initial begin
    int found;
    int br_exp[7];
    int m, t, len, r;
    bit e;

    vt[0] = '{0, 8'h00, 8'h00, 1, 1};
    vt[1] = '{0, 8'hFF, 8'hFF, 1, 1};
    vt[2] = '{3, 8'h10, 8'hFF, 0, 0};
    vt[3] = '{3, 8'hFF, 8'hFF, 1, 0};
    vt[4] = '{0, 8'h5A, 8'h5A, 1, 1};
    vt[5] = '{1, 8'h5A, 8'h5A, 1, 0};
    br_exp = '{8'h10, 8'h20, 8'h30, 8'h20, 8'h10, 8'h00, 8'h10};

    // Power-on reset
    repeat (3) cyc1();
    chk("por_duty", int'(duty_out), 0);
    chk("por_at_target", int'(at_target), 1);
    chk("por_upd", int'(duty_upd), 0);
    rst_n = 1'b1;
    ena   = 1'b1;

    // DIRECT latency: accept after 2+DEB+1 edges, duty on the following edge
    set_in(0, 8'hA0);
    watch(7, 1'b1);
    chk("direct_early", int'(duty_out), 8'h00);
    watch(1, 1'b0);
    chk("direct_duty", int'(duty_out), 8'hA0);
    chk("direct_upd", int'(duty_upd), 1);
    chk("direct_at", int'(at_target), 1);
    watch(10, 1'b1);
    chk("direct_single_upd", upd_cnt, 0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      set_in(vt[i].mode, vt[i].tgt);
      watch(12, 1'b1);
      chk($sformatf("vec%0d_duty", i), int'(duty_out), vt[i].exp_duty);
      chk($sformatf("vec%0d_at", i), int'(at_target), vt[i].exp_at);
      chk($sformatf("vec%0d_upd", i), upd_cnt, vt[i].exp_upd);
    end

    // Asynchronous reset mid-clock
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_duty", int'(duty_out), 0);
    chk("arst_at", int'(at_target), 1);
    chk("arst_upd", int'(duty_upd), 0);
    set_in(0, 0);
    cyc1();
    rst_n = 1'b1;
    watch(12, 1'b1);
    chk("post_rst_duty", int'(duty_out), 0);

    // RAMP 0 -> 0x40
    set_in(1, 8'h40);
    watch(40, 1'b1);
    chk("ramp_nchg", chg_val.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ramp_val%0d", i), qv(i), 16 * (i + 1));
    end
    chk("ramp_first_tick", (chg_cyc.size() > 0) ? chg_cyc[0] : -1, 12);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("ramp_gap%0d", i),
          (chg_cyc.size() > i) ? chg_cyc[i] - chg_cyc[i-1] : -1, RD);
    end
    chk("ramp_upd", upd_cnt, 4);
    chk("ramp_at", int'(at_target), 1);
    set_in(1, 8'h35);
    watch(20, 1'b1);
    chk("ramp_down_nchg", chg_val.size(), 1);
    chk("ramp_down_val", qv(0), 8'h35);
    chk("ramp_down_upd", upd_cnt, 1);

    // BREATHE 0 <-> 0x30
    set_in(0, 0);
    watch(12, 1'b1);
    set_in(2, 8'h30);
    watch(60, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("br_val%0d", i), qv(i), br_exp[i]);
    end
    set_in(2, 0);
    watch(20, 1'b1);
    chk("br_zero_duty", int'(duty_out), 0);
    watch(20, 1'b1);
    chk("br_zero_hold", chg_val.size(), 0);

    // Bounce on target bit 7
    set_in(0, 0);
    watch(12, 1'b1);
    for (int i = 0; i < 10; i++) begin
      set_in(0, (i % 2 == 0) ? 8'h80 : 8'h00);
      watch(2, (i == 0));
    end
    chk("bounce_quiet", chg_val.size(), 0);
    set_in(0, 8'h80);
    watch(12, 1'b0);
    chk("bounce_nchg", chg_val.size(), 1);
    chk("bounce_val", qv(0), 8'h80);
    chk("bounce_upd", upd_cnt, 1);

    // ena=0 freeze mid-ramp
    set_in(0, 0);
    watch(12, 1'b1);
    set_in(1, 8'h40);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      cyc1();
      if (duty_out == 8'h20) found = 1;
    end
    chk("ena_reach_20", found, 1);
    ena = 1'b0;
    watch(50, 1'b1);
    chk("ena_frozen_nchg", chg_val.size(), 0);
    chk("ena_frozen_upd", upd_cnt, 0);
    chk("ena_frozen_duty", int'(duty_out), 8'h20);
    ena = 1'b1;
    watch(RD - 1, 1'b1);
    chk("ena_resume_wait", chg_val.size(), 0);
    watch(1, 1'b1);
    chk("ena_resume_val", qv(0), 8'h30);
    chk("ena_resume_upd", int'(duty_upd), 1);

    // Randomized traffic against the model
    rst_n = 1'b0;
    cyc1();
    cyc1();
    rst_n = 1'b1;
    model_reset();
    for (int seg = 0; seg < 150; seg++) begin
      m   = $urandom_range(0, 3);
      r   = $urandom_range(0, 5);
      t   = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 255);
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        e = ($urandom_range(0, 7) != 0);
        ena = e;
        set_in(m, t);
        model_edge((m << 8) | t, e);
        cyc1();
        chk("rnd_duty", int'(duty_out), m_duty);
        chk("rnd_upd", int'(duty_upd), m_upd);
        chk("rnd_at", int'(at_target), (m_duty == m_tgt) ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
